// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - per-layer sequencer streaming bias + inputs into one MLP layer
module mlp_layer_sequencer #(
    parameter int                          N_INPUTS    = 3,
    parameter int                          IN_WIDTH    = 16,
    parameter logic signed [IN_WIDTH-1:0]  BIAS_VAL    = 256,
    parameter int                          RD_LATENCY  = 1,
    parameter int                          MAC_LATENCY = 1,
    localparam int                         IDX_W       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int                         FLAT_W      = (N_INPUTS > 1) ? (N_INPUTS - 1) * IN_WIDTH : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic [FLAT_W-1:0]          inputs_flat,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [IDX_W-1:0]           layer_input_index,
    output logic signed [IN_WIDTH-1:0] layer_input_value,
    output logic                       layer_start,
    output logic                       layer_valid,
    output logic                       layer_relu_en
);

    localparam int N_DATA    = (N_INPUTS > 1) ? N_INPUTS - 1 : 1;
    // DRAIN covers the read latency of the last index plus the MAC settle time
    localparam int DRAIN_CYC = RD_LATENCY + MAC_LATENCY - 1;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_INPUTS - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_RELU,
        S_DONE
    } state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic [DW-1:0]              drain_q;
    logic                       ready_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       relu_q;
    logic signed [IN_WIDTH-1:0] data_q [N_DATA];

    // Issue-stage value/flags for the index currently presented (head of the delay line)
    logic signed [IN_WIDTH-1:0] stage_value_d;
    logic                       stage_start_d;
    logic                       stage_valid_d;

    // Delay line aligning value/start/valid with the layer's weight-memory read
    logic signed [IN_WIDTH-1:0] val_pipe_q [RD_LATENCY];
    logic [RD_LATENCY-1:0]      start_pipe_q;
    logic [RD_LATENCY-1:0]      valid_pipe_q;

    generate
        if (N_INPUTS > 1) begin : g_data
            // Snapshot the input vector on acceptance so later changes are ignored
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < N_DATA; i++) data_q[i] <= '0;
                end else if (state_q == S_IDLE && go) begin
                    for (int i = 0; i < N_DATA; i++) data_q[i] <= inputs_flat[i*IN_WIDTH +: IN_WIDTH];
                end
            end
        end else begin : g_no_data
            assign data_q[0] = '0;
        end
    endgenerate

    // Select bias for index 0, otherwise the latched element for this index
    always_comb begin
        stage_value_d = '0;
        stage_start_d = 1'b0;
        stage_valid_d = 1'b0;
        if (state_q == S_ISSUE) begin
            if (idx_q == '0) begin
                stage_start_d = 1'b1;
                stage_value_d = BIAS_VAL;
            end else begin
                stage_valid_d = 1'b1;
                for (int i = 1; i < N_INPUTS; i++) begin
                    if (idx_q == IDX_W'(i)) stage_value_d = data_q[i-1];
                end
            end
        end
    end

    // Shift the issue stage through RD_LATENCY registers; a reset flushes everything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) val_pipe_q[i] <= '0;
            start_pipe_q <= '0;
            valid_pipe_q <= '0;
        end else begin
            val_pipe_q[0]   <= stage_value_d;
            start_pipe_q[0] <= stage_start_d;
            valid_pipe_q[0] <= stage_valid_d;
            for (int i = 1; i < RD_LATENCY; i++) begin
                val_pipe_q[i]   <= val_pipe_q[i-1];
                start_pipe_q[i] <= start_pipe_q[i-1];
                valid_pipe_q[i] <= valid_pipe_q[i-1];
            end
        end
    end

    // Control FSM: IDLE -> ISSUE (one index per cycle) -> DRAIN -> RELU -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            relu_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            relu_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q <= S_ISSUE;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // Index saturates at the last input; no wrap
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= S_RELU;
                        relu_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_RELU: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready             = ready_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign layer_relu_en     = relu_q;
    assign layer_input_index = idx_q;
    assign layer_input_value = val_pipe_q[RD_LATENCY-1];
    assign layer_start       = start_pipe_q[RD_LATENCY-1];
    assign layer_valid       = valid_pipe_q[RD_LATENCY-1];

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb/tb_mlp_layer_sequencer.sv - scoreboard bench for mlp_layer_sequencer in three configurations
module tb_mlp_layer_sequencer;

    typedef struct {
        int                 dut;
        int                 kind;   // 0 start, 1 valid, 2 relu_en, 3 done
        logic signed [15:0] value;
        int                 cyc;
    } ev_t;

    typedef struct {
        logic [31:0]        flat;
        logic signed [15:0] x1;
        logic signed [15:0] x2;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: defaults
    logic               go_a;
    logic [31:0]        flat_a;
    logic               ready_a, busy_a, done_a, start_a, valid_a, relu_a;
    logic [1:0]         idx_a;
    logic signed [15:0] val_a;

    // DUT B: N_INPUTS=5, RD_LATENCY=2, MAC_LATENCY=3
    logic               go_b;
    logic [63:0]        flat_b;
    logic               ready_b, busy_b, done_b, start_b, valid_b, relu_b;
    logic [2:0]         idx_b;
    logic signed [15:0] val_b;

    // DUT C: bias only
    logic               go_c;
    logic [0:0]         flat_c;
    logic               ready_c, busy_c, done_c, start_c, valid_c, relu_c;
    logic [0:0]         idx_c;
    logic signed [15:0] val_c;

    mlp_layer_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_n), .go(go_a), .inputs_flat(flat_a),
        .ready(ready_a), .busy(busy_a), .done(done_a),
        .layer_input_index(idx_a), .layer_input_value(val_a),
        .layer_start(start_a), .layer_valid(valid_a), .layer_relu_en(relu_a)
    );

    mlp_layer_sequencer #(.N_INPUTS(5), .RD_LATENCY(2), .MAC_LATENCY(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .inputs_flat(flat_b),
        .ready(ready_b), .busy(busy_b), .done(done_b),
        .layer_input_index(idx_b), .layer_input_value(val_b),
        .layer_start(start_b), .layer_valid(valid_b), .layer_relu_en(relu_b)
    );

    mlp_layer_sequencer #(.N_INPUTS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .go(go_c), .inputs_flat(flat_c),
        .ready(ready_c), .busy(busy_c), .done(done_c),
        .layer_input_index(idx_c), .layer_input_value(val_c),
        .layer_start(start_c), .layer_valid(valid_c), .layer_relu_en(relu_c)
    );

    ev_t                sbq[$];
    int                 acc_cnt [3];
    int                 acc_cyc [3];
    logic signed [15:0] a_x1, a_x2;
    logic signed [15:0] b_x [4];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    vec_t               tbl [4];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int k, input logic signed [15:0] v, input int c);
        ev_t e;
        e.dut = d; e.kind = k; e.value = v; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic check_ev(input int d, input logic s, input logic v, input logic r, input logic dn,
                            input logic signed [15:0] val);
        int j;
        int kind;
        if (s === 1'b1 || v === 1'b1 || r === 1'b1 || dn === 1'b1) begin
            chk($sformatf("dut%0d_single_event", d), $countones({s, v, r, dn}), 1);
            kind = s ? 0 : (v ? 1 : (r ? 2 : 3));
            j = -1;
            foreach (sbq[i]) if (j < 0 && sbq[i].dut == d) j = i;
            if (j < 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d_unexpected_event: got kind %0d value %0d, expected nothing (cycle %0d)",
                         d, kind, val, cyc);
            end else begin
                chk($sformatf("dut%0d_kind", d), kind, sbq[j].kind);
                chk($sformatf("dut%0d_value_k%0d", d, kind), val, sbq[j].value);
                chk($sformatf("dut%0d_cycle_k%0d", d, kind), cyc, sbq[j].cyc);
                sbq.delete(j);
            end
        end
    endtask

    // Scoreboard: check produced events, push expectations on each accepted command
    always @(negedge clk) begin
        check_ev(0, start_a, valid_a, relu_a, done_a, val_a);
        check_ev(1, start_b, valid_b, relu_b, done_b, val_b);
        check_ev(2, start_c, valid_c, relu_c, done_c, val_c);
        if (rst_n !== 1'b1) begin
            sbq.delete();
        end else begin
            if (go_a && ready_a) begin
                acc_cnt[0]++; acc_cyc[0] = cyc;
                push(0, 0, 16'sd256, cyc + 2);
                push(0, 1, a_x1,     cyc + 3);
                push(0, 1, a_x2,     cyc + 4);
                push(0, 2, 16'sd0,   cyc + 5);
                push(0, 3, 16'sd0,   cyc + 6);
            end
            if (go_b && ready_b) begin
                acc_cnt[1]++; acc_cyc[1] = cyc;
                push(1, 0, 16'sd256, cyc + 3);
                for (int k = 0; k < 4; k++) push(1, 1, b_x[k], cyc + 4 + k);
                push(1, 2, 16'sd0, cyc + 10);
                push(1, 3, 16'sd0, cyc + 11);
            end
            if (go_c && ready_c) begin
                acc_cnt[2]++; acc_cyc[2] = cyc;
                push(2, 0, 16'sd256, cyc + 2);
                push(2, 2, 16'sd0,   cyc + 3);
                push(2, 3, 16'sd0,   cyc + 4);
            end
        end
    end

    function automatic logic rdy(input int d);
        case (d)
            0:       return ready_a;
            1:       return ready_b;
            default: return ready_c;
        endcase
    endfunction

    task automatic set_go(input int d, input logic v);
        case (d)
            0:       go_a = v;
            1:       go_b = v;
            default: go_c = v;
        endcase
    endtask

    task automatic wait_acc(input int d, input int prev);
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (acc_cnt[d] != prev) begin ok = 1; break; end
        end
        chk($sformatf("dut%0d_accept_in_time", d), ok, 1);
    endtask

    task automatic run(input int d);
        int prev;
        prev = acc_cnt[d];
        set_go(d, 1'b1);
        wait_acc(d, prev);
        set_go(d, 1'b0);
    endtask

    task automatic wait_idle(input int d);
        bit ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (rdy(d)) begin ok = 1; break; end
        end
        chk($sformatf("dut%0d_idle_in_time", d), ok, 1);
    endtask

    task automatic wait_to(input int c);
        for (int k = 0; k < 100 && cyc < c; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load_a(input int i);
        flat_a = tbl[i].flat;
        a_x1   = tbl[i].x1;
        a_x2   = tbl[i].x2;
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_ready"}, ready_a, 1);
        chk({tag, "_busy"},  busy_a,  0);
        chk({tag, "_done"},  done_a,  0);
        chk({tag, "_start"}, start_a, 0);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_relu"},  relu_a,  0);
        chk({tag, "_index"}, idx_a,   0);
        chk({tag, "_value"}, val_a,   0);
    endtask

    initial begin
        int c0;
        int first;
        int prev;

        tbl[0] = '{32'h0200_FF00,  -16'sd256,   16'sd512};
        tbl[1] = '{32'h7FFF_8000,  -16'sd32768, 16'sd32767};
        tbl[2] = '{32'h0000_0000,  16'sd0,      16'sd0};
        tbl[3] = '{32'hFFFF_0001,  16'sd1,      -16'sd1};

        rst_n = 1'b0;
        go_a = 1'b0; go_b = 1'b0; go_c = 1'b0;
        flat_a = '0; flat_b = '0; flat_c = '0;
        a_x1 = '0; a_x2 = '0;
        b_x = '{16'sd10, -16'sd20, 16'sd300, -16'sd4000};

        repeat (3) @(posedge clk);
        #1;
        check_reset_a("reset");
        chk("reset_ready_b", ready_b, 1);
        chk("reset_busy_c",  busy_c,  0);
        rst_n = 1'b1;

        // Basic command: index timing, ready/busy/done around the sequence
        load_a(0);
        run(0);
        c0 = acc_cyc[0];
        chk("s1_busy_c0p1",  busy_a,  1);
        chk("s1_ready_c0p1", ready_a, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s1_index_c0p%0d", k + 1), idx_a, k);
            @(posedge clk); #1;
        end
        wait_to(c0 + 6);
        chk("s1_done_c0p6",  done_a,  1);
        chk("s1_ready_c0p6", ready_a, 0);
        @(posedge clk); #1;
        chk("s1_ready_c0p7", ready_a, 1);
        chk("s1_busy_c0p7",  busy_a,  0);
        chk("s1_index_hold", idx_a,   2);

        // Table-driven commands
        for (int i = 1; i < 4; i++) begin
            load_a(i);
            run(0);
            wait_idle(0);
        end

        // Input vector overwritten right after acceptance
        load_a(3);
        run(0);
        flat_a = '1;
        wait_idle(0);

        // go held high: second command only after done
        load_a(1);
        prev = acc_cnt[0];
        go_a = 1'b1;
        wait_acc(0, prev);
        first = acc_cyc[0];
        load_a(2);
        prev = acc_cnt[0];
        wait_acc(0, prev);
        go_a = 1'b0;
        chk("held_go_reaccept_gap", acc_cyc[0] - first, 7);
        wait_idle(0);

        // Reset in the middle of a command
        load_a(0);
        run(0);
        c0 = acc_cyc[0];
        wait_to(c0 + 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_a("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_still_idle", ready_a, 1);
        load_a(0);
        run(0);
        wait_idle(0);

        // Longer read/MAC latencies with five inputs
        flat_b = {-16'sd4000, 16'sd300, -16'sd20, 16'sd10};
        run(1);
        flat_b = '1;
        wait_idle(1);
        chk("b_index_hold", idx_b, 4);

        // Bias-only layer
        run(2);
        wait_idle(2);
        chk("c_index", idx_c, 0);

        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule
